mux_stim_seq: RTL and testbench
===============================

Name: mux_stim_seq

Overview:
- Synchronous stimulus sequencer that sits directly upstream of the 2:1 dataflow mux (muxdatflowstyle).
- Drives the mux's a[1:0] and s inputs through all 8 {s,a} combinations in order, holding each one for a programmable number of clocks.
- Reads the mux output y back so the sequence runs in hardware instead of relying on #-delays in a bench.
- Optional self-check compares y against the expected mux result and counts mismatches.

Parameters:
- DWELL, 5, clocks each vector is held; legal range ≥1. Counter width is sized to hold DWELL-1.
- LOOP, 0: 1 wraps from vector 7 back to 0 and runs forever; 0 stops after vector 7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sequence
- stop  in  1  abort the running sequence
- y  in  1  mux output, fed back
- a  out  2  mux data inputs (registered)
- s  out  1  mux select (registered)
- vec_idx  out  3  current vector index = {s,a}
- vec_valid  out  1  a/s carry a live vector
- busy  out  1  sequencer in DRIVE
- done  out  1  sequence completed (LOOP=0 only)
- err  out  1  sticky mismatch flag
- err_cnt  out  4  mismatch count, saturating

Behaviour:
- Reset: all outputs are 0, and the state is IDLE. Reset applies on any clock edge with rst=1, including mid-sequence. Reset has priority over start and stop.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 and stop=0 → DRIVE on the next edge, with vec_idx=0 and the dwell counter at 0.
  - start=1 and stop=1 → remain in IDLE (stop wins).
- DRIVE:
  - busy=1, vec_valid=1, a=vec_idx[1:0], s=vec_idx[2].
  - The dwell counter counts 0..DWELL-1. On count DWELL-1, vec_idx increments and the counter clears.
  - Timing: DRIVE is entered at cycle T. Vector k occupies cycles T+k·DWELL through T+(k+1)·DWELL-1.
  - start is ignored in DRIVE.
  - stop=1 → IDLE on the next edge; a, s, vec_idx, vec_valid and busy all return to 0.
- End of vector 7:
  - LOOP=0 → DONE at cycle T+8·DWELL: done=1, busy=0, vec_valid=0, a=0, s=0, vec_idx=0.
  - LOOP=1 → vec_idx wraps 7→0 and the sequence continues with no gap; done never asserts.
- DONE:
  - done is held until start is received.
  - start → DRIVE on the next edge, done=0, vec_idx=0.
  - stop has no effect in DONE.
- DWELL=1: the vector changes every clock. The sequence lasts 8 cycles, and done asserts at T+8.
- Any start that launches a sequence clears err and err_cnt, on the same edge that enters DRIVE.

Optional Feature:
- Macro: MUX_STIM_CHECK_EN.
- When defined:
  - y is sampled on the last dwell cycle of each vector (counter = DWELL-1), which gives the combinational mux time to settle.
  - Expected value = s ? a[1] : a[0], computed from the current registered outputs.
  - On a mismatch, err is set (sticky) and err_cnt increments, saturating at 15.
  - Sampling happens only in DRIVE. No sample is taken on the edge where stop aborts.
- When not defined: y is unused, and err and err_cnt are constant 0.

Test Plan:
- DWELL=5, LOOP=0, start pulse, ideal mux: a/s step through 00/0, 01/0, 10/0, 11/0, 00/1, 01/1, 10/1, 11/1, each held for 5 clocks. done rises 40 clocks after DRIVE entry. err_cnt=0 (with check enabled).
- Check enabled, y tied to 0: mismatches on vec_idx 1, 3, 6 and 7. Expect err_cnt=4 and err=1 at done. A following start clears both to 0.
- Check enabled, y swapped (y = s ? a[0] : a[1]): mismatches on vec_idx 1, 2, 5 and 6. Expect err_cnt=4.
- Assert stop during vec_idx=3: next clock is IDLE with a=0, s=0, vec_valid=0, busy=0 and done=0. start and stop asserted together in IDLE keep the block in IDLE.
- LOOP=1, DWELL=1: vec_idx follows 0..7,0,1,... every clock and done stays 0. rst=1 mid-run returns all outputs to 0 on the next edge.
- DWELL=2, LOOP=0: done is asserted exactly 16 clocks after DRIVE entry. A start received in DONE restarts at vec_idx=0 on the next edge.

Source files
------------

// File: rtl/mux_stim_seq.sv
// rtl/mux_stim_seq.sv - walks a 2:1 mux through all 8 {s,a} vectors with a programmable dwell
// Optional y self-check compiled in with `define MUX_STIM_CHECK_EN.
module mux_stim_seq #(
    parameter int DWELL = 5,
    parameter bit LOOP  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       y,
    output logic [1:0] a,
    output logic       s,
    output logic [2:0] vec_idx,
    output logic       vec_valid,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_cnt
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    next_idx;
    logic          launch;
    logic          sample;

    assign next_idx = vec_idx + 3'd1;
    // stop only vetoes a launch from IDLE; in DONE start alone is enough
    assign launch   = start && (((state == IDLE) && !stop) || (state == DONE));
    assign sample   = (state == DRIVE) && !stop && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            vec_idx   <= 3'd0;
            a         <= 2'd0;
            s         <= 1'b0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        state     <= DRIVE;
                        cnt       <= '0;
                        vec_idx   <= 3'd0;
                        a         <= 2'd0;
                        s         <= 1'b0;
                        vec_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (stop) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        vec_idx   <= 3'd0;
                        a         <= 2'd0;
                        s         <= 1'b0;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        if ((vec_idx == 3'd7) && !LOOP) begin
                            state     <= DONE;
                            vec_idx   <= 3'd0;
                            a         <= 2'd0;
                            s         <= 1'b0;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            // with LOOP the 3-bit index wraps 7->0 on its own
                            vec_idx <= next_idx;
                            a       <= next_idx[1:0];
                            s       <= next_idx[2];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUX_STIM_CHECK_EN
    logic expected;
    assign expected = s ? a[1] : a[0];

    // y is judged on the last dwell cycle so the downstream mux has settled
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err     <= 1'b0;
            err_cnt <= 4'd0;
        end else if (sample && (y != expected)) begin
            err <= 1'b1;
            if (err_cnt != 4'hF) begin
                err_cnt <= err_cnt + 4'd1;
            end
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = y ^ sample;
    assign err           = 1'b0;
    assign err_cnt       = 4'd0;
`endif

endmodule

// File: tb/tb_mux_stim_seq.sv
// tb/tb_mux_stim_seq.sv - scoreboard bench running three mux_stim_seq configurations in lockstep
// Configs: DWELL=5/LOOP=0, DWELL=1/LOOP=1, DWELL=2/LOOP=0; honours MUX_STIM_CHECK_EN.
module tb_mux_stim_seq;

    typedef struct packed {
        logic [1:0] a;
        logic       s;
        logic [2:0] idx;
        logic       vv;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] ec;
    } obs_t;

    typedef obs_t [2:0] trio_t;

`ifdef MUX_STIM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam int DW [3] = '{5, 1, 2};
    localparam bit LP [3] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    int   mode = 0;

    always #5 clk = ~clk;

    // environment mux: 0 ideal, 1 output stuck at 0, 2 data inputs swapped
    function automatic logic env_mux(input logic [1:0] av, input logic sv, input int md);
        if (md == 1) return 1'b0;
        if (md == 2) return sv ? av[0] : av[1];
        return sv ? av[1] : av[0];
    endfunction

    logic [1:0] a0, a1, a2;
    logic       s0, s1, s2;
    logic [2:0] idx0, idx1, idx2;
    logic       vv0, vv1, vv2, busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;
    logic [3:0] ec0, ec1, ec2;
    logic       y0, y1, y2;

    assign y0 = env_mux(a0, s0, mode);
    assign y1 = env_mux(a1, s1, mode);
    assign y2 = env_mux(a2, s2, mode);

    mux_stim_seq #(.DWELL(5), .LOOP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .y(y0),
        .a(a0), .s(s0), .vec_idx(idx0), .vec_valid(vv0), .busy(busy0),
        .done(done0), .err(err0), .err_cnt(ec0)
    );

    mux_stim_seq #(.DWELL(1), .LOOP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .y(y1),
        .a(a1), .s(s1), .vec_idx(idx1), .vec_valid(vv1), .busy(busy1),
        .done(done1), .err(err1), .err_cnt(ec1)
    );

    mux_stim_seq #(.DWELL(2), .LOOP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .y(y2),
        .a(a2), .s(s2), .vec_idx(idx2), .vec_valid(vv2), .busy(busy2),
        .done(done2), .err(err2), .err_cnt(ec2)
    );

    // reference model: phase 0 idle, 1 running, 2 finished; t counts clocks since the run began
    int    phase [3];
    int    t     [3];
    int    mcnt  [3];
    bit    merr  [3];
    trio_t exp_q [$];
    int    vectors = 0;
    int    miscompares = 0;

    task automatic model(input int i, input logic r, input logic go, input logic halt,
                         input int md, output obs_t o);
        int         k;
        logic [1:0] ea;
        logic       es;
        if (r) begin
            phase[i] = 0; t[i] = 0; mcnt[i] = 0; merr[i] = 1'b0;
        end else if (phase[i] == 1) begin
            if (halt) begin
                phase[i] = 0;
            end else begin
                if ((t[i] % DW[i]) == DW[i] - 1) begin
                    k  = (t[i] / DW[i]) % 8;
                    ea = k[1:0];
                    es = k[2];
                    if (CHECK_EN && (env_mux(ea, es, md) != (es ? ea[1] : ea[0]))) begin
                        merr[i] = 1'b1;
                        if (mcnt[i] < 15) mcnt[i] = mcnt[i] + 1;
                    end
                end
                t[i] = t[i] + 1;
                if (t[i] == 8 * DW[i]) begin
                    if (LP[i]) t[i] = 0;
                    else phase[i] = 2;
                end
            end
        end else if (go && ((phase[i] == 2) || !halt)) begin
            phase[i] = 1; t[i] = 0; mcnt[i] = 0; merr[i] = 1'b0;
        end
        o = '0;
        if (phase[i] == 1) begin
            k     = (t[i] / DW[i]) % 8;
            o.a   = k[1:0];
            o.s   = k[2];
            o.idx = k[2:0];
            o.vv  = 1'b1;
            o.busy = 1'b1;
        end
        o.done = (phase[i] == 2);
        o.err  = merr[i];
        o.ec   = mcnt[i][3:0];
    endtask

    task automatic step(input logic r, input logic go, input logic halt, input int md);
        trio_t e;
        @(negedge clk);
        rst = r; start = go; stop = halt; mode = md;
        for (int i = 0; i < 3; i++) model(i, r, go, halt, md, e[i]);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input int md);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, md);
    endtask

    always @(posedge clk) begin
        trio_t e;
        trio_t act;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act[0] = obs_t'({a0, s0, idx0, vv0, busy0, done0, err0, ec0});
            act[1] = obs_t'({a1, s1, idx1, vv1, busy1, done1, err1, ec1});
            act[2] = obs_t'({a2, s2, idx2, vv2, busy2, done2, err2, ec2});
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (act[i] !== e[i]) begin
                    miscompares++;
                    $display("FAIL cfg%0d(dwell=%0d) outputs @%0t: got a=%b s=%b idx=%0d vv=%b busy=%b done=%b err=%b cnt=%0d, want a=%b s=%b idx=%0d vv=%b busy=%b done=%b err=%b cnt=%0d",
                             i, DW[i], $time, act[i].a, act[i].s, act[i].idx, act[i].vv,
                             act[i].busy, act[i].done, act[i].err, act[i].ec, e[i].a, e[i].s,
                             e[i].idx, e[i].vv, e[i].busy, e[i].done, e[i].err, e[i].ec);
                end
            end
        end
    end

    initial begin
        int md;
        int waited;
        for (int i = 0; i < 3; i++) begin
            phase[i] = 0; t[i] = 0; mcnt[i] = 0; merr[i] = 1'b0;
        end
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);
        vectors++;
        if ({a0, s0, idx0, vv0, busy0, done0, err0, ec0,
             a1, s1, idx1, vv1, busy1, done1, err1, ec1,
             a2, s2, idx2, vv2, busy2, done2, err2, ec2} !== '0) begin
            miscompares++;
            $display("FAIL reset state @%0t: outputs not all zero", $time);
        end
        idle(2, 0);
        // full pass with an ideal mux
        step(1'b0, 1'b1, 1'b0, 0);
        waited = 0;
        while ((done0 !== 1'b1) && (waited < 60)) begin
            idle(1, 0);
            waited++;
        end
        vectors++;
        if (done0 !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout @%0t: done never asserted within %0d clocks", $time, waited);
        end
        if (waited < 49) idle(49 - waited, 0);
        // y stuck at 0, then a restart that must clear the error state
        step(1'b0, 1'b1, 1'b0, 1);
        idle(44, 1);
        step(1'b0, 1'b1, 1'b0, 1);
        idle(5, 1);
        // swapped mux inputs
        step(1'b0, 1'b1, 1'b0, 2);
        idle(44, 2);
        // abort during vector 3 of the DWELL=5 run, then start+stop together in IDLE
        step(1'b0, 1'b1, 1'b0, 0);
        idle(17, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        idle(1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        idle(3, 0);
        // reset in the middle of a run
        step(1'b0, 1'b1, 1'b0, 0);
        idle(9, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(3, 0);
        // randomized control traffic
        md = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) md = int'($urandom_range(0, 2));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 39) == 0, md);
        end
        idle(2, md);
        @(posedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
